// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    DONE      = 2'd3
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int unsigned WD_WIDTH = 8;

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module sdram_arb_rr_pick
  import sdram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = PORT0;
    case (req)
      2'b10:   grant = PORT1;
      2'b11:   grant = ~last;
      default: grant = PORT0;
    endcase
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates two request/done ports onto one SDRAM controller command interface,
// with a watchdog that force-completes a transaction the controller never finishes.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_done,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_done,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_out_valid,
  input  logic                  mem_bus_busy,
  output logic                  arb_timeout
);

  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic [WD_WIDTH-1:0]   wd_q, wd_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  tmo_q, tmo_d;

  logic                  pick;
  logic [WD_WIDTH-1:0]   wd_inc;
  logic                  wd_hit;

  sdram_arb_rr_pick u_pick (
    .req   ({p1_req, p0_req}),
    .last  (last_q),
    .grant (pick)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    wd_d     = wd_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    tmo_d    = 1'b0;
    // Saturating increment; the hit is judged on the value the counter is about to take.
    wd_inc   = (wd_q == '1) ? wd_q : wd_q + WD_WIDTH'(1);
    wd_hit   = (wd_inc == WD_LIMIT);

    case (state_q)
      IDLE: begin
        if ((p0_req || p1_req) && !mem_bus_busy) begin
          owner_d = pick;
          if (pick == PORT1) begin
            we_d    = p1_we;
            addr_d  = p1_addr;
            wdata_d = p1_wdata;
          end else begin
            we_d    = p0_we;
            addr_d  = p0_addr;
            wdata_d = p0_wdata;
          end
          wd_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d = wd_inc;
        if (wd_hit) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end else if (mem_bus_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wd_d = wd_inc;
        if (!we_q && mem_data_out_valid) begin
          if (owner_q == PORT1) rdata1_d = mem_data_out;
          else                  rdata0_d = mem_data_out;
        end
        if (!mem_bus_busy) begin
          state_d = DONE;
        end else if (wd_hit) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= PORT1;
      owner_q  <= PORT0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      wd_q     <= wd_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      tmo_q    <= tmo_d;
    end
  end

  assign mem_rd_en   = (state_q == ISSUE) && !we_q;
  assign mem_wr_en   = (state_q == ISSUE) && we_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign p0_done     = (state_q == DONE) && (owner_q == PORT0);
  assign p1_done     = (state_q == DONE) && (owner_q == PORT1);
  assign p0_rdata    = rdata0_q;
  assign p1_rdata    = rdata1_q;
  assign arb_timeout = tmo_q;

endmodule
